pio_sequencer: RTL and testbench

Host-side controller for one PIO state machine. On a start pulse it drives the PIO action bus to load the program and configuration, then enables the machine. While running it shares the single action bus between a TX stream (PUSH) and an RX stream (PULL), scheduling them round-robin against the PIO's tx_full and rx_empty flags.

---
 rtl/pio_pkg.sv | 30 +++
 rtl/pio_seq_arb.sv | 40 ++++
 rtl/pio_sequencer.sv | 170 +++++++++++++++++
 tb/tb_pio_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - shared action codes, sequencer states and field widths for pio_sequencer
package pio_pkg;

    localparam int IDX_W  = 5;
    localparam int PLEN_W = 6;
    localparam int ACT_W  = 4;
    localparam int DATA_W = 32;

    localparam logic [ACT_W-1:0] NONE  = 4'd0;
    localparam logic [ACT_W-1:0] INSTR = 4'd1;
    localparam logic [ACT_W-1:0] PEND  = 4'd2;
    localparam logic [ACT_W-1:0] PULL  = 4'd3;
    localparam logic [ACT_W-1:0] PUSH  = 4'd4;
    localparam logic [ACT_W-1:0] GRPS  = 4'd5;
    localparam logic [ACT_W-1:0] EN    = 4'd6;
    localparam logic [ACT_W-1:0] DIV   = 4'd7;
    localparam logic [ACT_W-1:0] SIDES = 4'd8;
    localparam logic [ACT_W-1:0] IMM   = 4'd9;
    localparam logic [ACT_W-1:0] SHIFT = 4'd10;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_INSTR, S_PEND, S_DIV, S_GRPS, S_SHIFT, S_EN, S_RUN, S_DIS
    } state_e;

    // Program length can never exceed the 32-entry program memory.
    function automatic logic [PLEN_W-1:0] clamp_plen(input logic [PLEN_W-1:0] p);
        return (p > 6'd32) ? 6'd32 : p;
    endfunction

endpackage

// File: rtl/pio_seq_arb.sv
// rtl/pio_seq_arb.sv - round-robin PUSH/PULL arbiter with one forced idle cycle after each grant
module pio_seq_arb (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    input  logic push_req,
    input  logic pull_req,
    output logic push_gnt,
    output logic pull_gnt
);

    logic guard_q, guard_d;
    logic last_push_q, last_push_d;
    logic ok;

    // last_push_q resets to 0 so the first contested grant goes to push.
    always_comb begin
        ok          = en && !guard_q;
        push_gnt    = ok && push_req && (!pull_req || !last_push_q);
        pull_gnt    = ok && pull_req && (!push_req || last_push_q);
        guard_d     = push_gnt || pull_gnt;
        last_push_d = last_push_q;
        if (push_gnt) begin
            last_push_d = 1'b1;
        end else if (pull_gnt) begin
            last_push_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            guard_q     <= 1'b0;
            last_push_q <= 1'b0;
        end else begin
            guard_q     <= guard_d;
            last_push_q <= last_push_d;
        end
    end

endmodule

// File: rtl/pio_sequencer.sv
// rtl/pio_sequencer.sv - loads and enables one PIO state machine, then shares its action bus between TX and RX
module pio_sequencer
    import pio_pkg::*;
#(
    parameter int PROG_DEPTH = 32,
    parameter int SM_INDEX   = 0,
    parameter int PULL_LAT   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        prog_we,
    input  logic [4:0]  prog_addr,
    input  logic [15:0] prog_data,
    input  logic [5:0]  cfg_plen,
    input  logic [23:0] cfg_div,
    input  logic [31:0] cfg_pin_grps,
    input  logic [31:0] cfg_exec_ctrl,
    input  logic [31:0] cfg_shift,
    input  logic        start,
    input  logic        stop,
    output logic        busy,
    output logic        running,
    input  logic [31:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [3:0]  action,
    output logic [4:0]  index,
    output logic [1:0]  mindex,
    output logic [31:0] din,
    input  logic [31:0] pio_dout,
    input  logic [3:0]  tx_full,
    input  logic [3:0]  rx_empty
);

    logic [15:0]          mem_q [PROG_DEPTH];
    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [PLEN_W-1:0]    plen_q;
    logic [23:0]          div_q;
    logic [31:0]          grps_q, exec_q, shift_q;
    logic                 cap;
    logic [PULL_LAT-1:0]  pipe_q, pipe_d;
    logic                 rx_valid_q;
    logic [31:0]          rx_data_q;
    logic                 arb_en, push_req, pull_req, push_gnt, pull_gnt;
    logic                 unused_flags;

    assign unused_flags = ^{tx_full, rx_empty};

    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    assign arb_en   = (state_q == S_RUN);
    assign push_req = tx_valid && !tx_full[SM_INDEX];
    assign pull_req = !rx_valid_q && (pipe_q == '0) && !rx_empty[SM_INDEX];

    pio_seq_arb u_arb (
        .clk      (clk),
        .resetn   (reset),
        .en       (arb_en),
        .push_req (push_req),
        .pull_req (pull_req),
        .push_gnt (push_gnt),
        .pull_gnt (pull_gnt)
    );

    assign tx_ready = push_gnt;
    assign running  = (state_q == S_RUN);
    assign busy     = (state_q != S_IDLE) && (state_q != S_RUN);
    assign mindex   = 2'(SM_INDEX);
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign pipe_d   = (pipe_q << 1) | PULL_LAT'(pull_gnt);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cap     = 1'b0;
        action  = NONE;
        index   = '0;
        din     = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cap     = 1'b1;
                    idx_d   = '0;
                    state_d = (clamp_plen(cfg_plen) == '0) ? S_PEND : S_LOAD_INSTR;
                end
            end
            S_LOAD_INSTR: begin
                action = INSTR;
                index  = idx_q;
                din    = {16'h0, mem_q[idx_q]};
                if ({1'b0, idx_q} == plen_q - 6'd1) begin
                    state_d = S_PEND;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            S_PEND:  begin action = PEND;  din = exec_q;          state_d = S_DIV;   end
            S_DIV:   begin action = DIV;   din = {8'h0, div_q};   state_d = S_GRPS;  end
            S_GRPS:  begin action = GRPS;  din = grps_q;          state_d = S_SHIFT; end
            S_SHIFT: begin action = SHIFT; din = shift_q;         state_d = S_EN;    end
            S_EN:    begin action = EN;    din = 32'd1;           state_d = S_RUN;   end
            S_RUN: begin
                if (push_gnt) begin
                    action = PUSH;
                    din    = tx_data;
                end else if (pull_gnt) begin
                    action = PULL;
                end
                if (stop) begin
                    state_d = S_DIS;
                end
            end
            S_DIS:   begin action = EN; state_d = S_IDLE; end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            plen_q  <= '0;
            div_q   <= '0;
            grps_q  <= '0;
            exec_q  <= '0;
            shift_q <= '0;
        end else if (cap) begin
            plen_q  <= clamp_plen(cfg_plen);
            div_q   <= cfg_div;
            grps_q  <= cfg_pin_grps;
            exec_q  <= cfg_exec_ctrl;
            shift_q <= cfg_shift;
        end
    end

    // A pull in flight keeps completing after stop; only reset cancels it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pipe_q     <= '0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            pipe_q <= pipe_d;
            if (pipe_q[PULL_LAT-1]) begin
                rx_valid_q <= 1'b1;
                rx_data_q  <= pio_dout;
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pio_sequencer.sv
// tb/tb_pio_sequencer.sv - directed self-checking bench for pio_sequencer
module tb_pio_sequencer;

    localparam logic [3:0] A_NONE = 4'd0, A_INSTR = 4'd1, A_PEND = 4'd2, A_PULL = 4'd3;
    localparam logic [3:0] A_PUSH = 4'd4, A_GRPS = 4'd5, A_EN = 4'd6, A_DIV = 4'd7, A_SHIFT = 4'd10;

    logic        clk = 1'b0;
    logic        reset, prog_we, start, stop, tx_valid, rx_ready;
    logic [4:0]  prog_addr;
    logic [15:0] prog_data;
    logic [5:0]  cfg_plen;
    logic [23:0] cfg_div;
    logic [31:0] cfg_pin_grps, cfg_exec_ctrl, cfg_shift, tx_data, pio_dout;
    logic [3:0]  tx_full, rx_empty;
    logic        busy, running, tx_ready, rx_valid;
    logic [31:0] rx_data, din;
    logic [3:0]  action;
    logic [4:0]  index;
    logic [1:0]  mindex;

    int checks = 0;
    int failures = 0;
    logic [15:0] tb_mem [32];

    always #5 clk = ~clk;

    pio_sequencer dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .cfg_plen(cfg_plen), .cfg_div(cfg_div), .cfg_pin_grps(cfg_pin_grps),
        .cfg_exec_ctrl(cfg_exec_ctrl), .cfg_shift(cfg_shift), .start(start), .stop(stop),
        .busy(busy), .running(running), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .action(action), .index(index),
        .mindex(mindex), .din(din), .pio_dout(pio_dout), .tx_full(tx_full), .rx_empty(rx_empty)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic exp_act(input string tag, input logic [3:0] a, input logic [4:0] i, input logic [31:0] d);
        #1;
        chk({tag, ".action"}, 32'(action), 32'(a));
        chk({tag, ".index"}, 32'(index), 32'(i));
        chk({tag, ".din"}, din, d);
    endtask

    task automatic do_load(input logic [5:0] plen_in, input int n_instr);
        cfg_plen = plen_in;
        tick(); start = 1'b1;
        tick(); start = 1'b0;
        for (int i = 0; i < n_instr; i++) begin
            exp_act("instr", A_INSTR, 5'(i), {16'h0, tb_mem[i]});
            chk("instr.busy", 32'(busy), 32'd1);
            tick();
        end
        exp_act("pend", A_PEND, 5'd0, 32'h0000_1000);   tick();
        exp_act("div", A_DIV, 5'd0, 32'h0000_0C80);     tick();
        exp_act("grps", A_GRPS, 5'd0, 32'h2010_0001);   tick();
        exp_act("shift", A_SHIFT, 5'd0, 32'h1083_0000); tick();
        exp_act("en", A_EN, 5'd0, 32'd1);
        chk("en.running", 32'(running), 32'd0);
        tick();
        exp_act("run0", A_NONE, 5'd0, 32'd0);
        chk("run0.running", 32'(running), 32'd1);
        chk("run0.busy", 32'(busy), 32'd0);
    endtask

    task automatic do_stop();
        tick(); stop = 1'b1;
        tick(); stop = 1'b0;
        exp_act("dis", A_EN, 5'd0, 32'd0);
        chk("dis.busy", 32'(busy), 32'd1);
        chk("dis.running", 32'(running), 32'd0);
        tick();
        exp_act("idle", A_NONE, 5'd0, 32'd0);
        chk("idle.busy", 32'(busy), 32'd0);
        chk("idle.running", 32'(running), 32'd0);
    endtask

    initial begin
        reset = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; start = 1'b0; stop = 1'b0;
        cfg_plen = '0; cfg_div = 24'h000C80; cfg_pin_grps = 32'h2010_0001;
        cfg_exec_ctrl = 32'h0000_1000; cfg_shift = 32'h1083_0000;
        tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; pio_dout = '0; tx_full = '0; rx_empty = 4'hF;

        tick(); tick();
        exp_act("rst", A_NONE, 5'd0, 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.running", 32'(running), 32'd0);
        chk("rst.tx_ready", 32'(tx_ready), 32'd0);
        chk("rst.rx_valid", 32'(rx_valid), 32'd0);
        chk("rst.rx_data", rx_data, 32'd0);
        chk("rst.mindex", 32'(mindex), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 32; i++) begin
            tick();
            prog_we = 1'b1;
            prog_addr = 5'(i);
            prog_data = (i == 0) ? 16'h6001 : (i == 1) ? 16'h4001 : 16'(16'hA000 + i);
            tb_mem[i] = prog_data;
        end
        tick(); prog_we = 1'b0;

        do_load(6'd2, 2);

        tick(); tx_valid = 1'b1; tx_data = 32'h4000_0000;
        exp_act("push0", A_PUSH, 5'd0, 32'h4000_0000); chk("push0.tx_ready", 32'(tx_ready), 32'd1);
        tick(); tx_data = 32'h8000_0000;
        exp_act("guard0", A_NONE, 5'd0, 32'd0); chk("guard0.tx_ready", 32'(tx_ready), 32'd0);
        tick();
        exp_act("push1", A_PUSH, 5'd0, 32'h8000_0000); chk("push1.tx_ready", 32'(tx_ready), 32'd1);
        tick(); tx_valid = 1'b0;
        exp_act("guard1", A_NONE, 5'd0, 32'd0);
        tick(); tx_valid = 1'b1; tx_data = 32'h1234_5678; tx_full = 4'h1;
        exp_act("full0", A_NONE, 5'd0, 32'd0); chk("full0.tx_ready", 32'(tx_ready), 32'd0);
        tick();
        exp_act("full1", A_NONE, 5'd0, 32'd0);
        tick(); tx_full = 4'h0;
        exp_act("unfull", A_PUSH, 5'd0, 32'h1234_5678); chk("unfull.tx_ready", 32'(tx_ready), 32'd1);
        tick(); tx_valid = 1'b0;
        exp_act("guard2", A_NONE, 5'd0, 32'd0);

        // Both streams eligible; last grant was a push, so pull goes first.
        tick(); tx_valid = 1'b1; tx_data = 32'hCAFE_0001; rx_empty = 4'hE; rx_ready = 1'b1; pio_dout = 32'hDEAD_DEAD;
        exp_act("alt0", A_PULL, 5'd0, 32'd0); chk("alt0.tx_ready", 32'(tx_ready), 32'd0);
        tick(); pio_dout = 32'h1111_1111;
        exp_act("alt1", A_NONE, 5'd0, 32'd0); chk("alt1.rx_valid", 32'(rx_valid), 32'd0);
        tick(); pio_dout = 32'hDEAD_DEAD;
        exp_act("alt2", A_PUSH, 5'd0, 32'hCAFE_0001);
        chk("alt2.rx_valid", 32'(rx_valid), 32'd1); chk("alt2.rx_data", rx_data, 32'h1111_1111);
        tick();
        exp_act("alt3", A_NONE, 5'd0, 32'd0); chk("alt3.rx_valid", 32'(rx_valid), 32'd0);
        tick();
        exp_act("alt4", A_PULL, 5'd0, 32'd0);
        tick(); pio_dout = 32'h2222_2222;
        exp_act("alt5", A_NONE, 5'd0, 32'd0);
        tick(); pio_dout = 32'h0; rx_ready = 1'b0;
        exp_act("alt6", A_PUSH, 5'd0, 32'hCAFE_0001);
        chk("alt6.rx_valid", 32'(rx_valid), 32'd1); chk("alt6.rx_data", rx_data, 32'h2222_2222);
        tick();
        exp_act("alt7", A_NONE, 5'd0, 32'd0); chk("alt7.rx_valid", 32'(rx_valid), 32'd1);
        tick();
        exp_act("blk", A_PUSH, 5'd0, 32'hCAFE_0001); chk("blk.rx_data", rx_data, 32'h2222_2222);
        tick(); tx_valid = 1'b0; rx_ready = 1'b1;
        exp_act("alt9", A_NONE, 5'd0, 32'd0);

        // Stop lands on a PULL cycle; its capture must still complete.
        tick(); stop = 1'b1;
        exp_act("stop_pull", A_PULL, 5'd0, 32'd0); chk("stop_pull.rx_valid", 32'(rx_valid), 32'd0);
        tick(); stop = 1'b0; pio_dout = 32'h3333_3333; rx_empty = 4'hF;
        exp_act("stop_dis", A_EN, 5'd0, 32'd0);
        chk("stop_dis.busy", 32'(busy), 32'd1); chk("stop_dis.running", 32'(running), 32'd0);
        tick();
        exp_act("stop_idle", A_NONE, 5'd0, 32'd0);
        chk("stop_idle.running", 32'(running), 32'd0); chk("stop_idle.busy", 32'(busy), 32'd0);
        chk("stop_idle.rx_valid", 32'(rx_valid), 32'd1); chk("stop_idle.rx_data", rx_data, 32'h3333_3333);
        tick();
        exp_act("rx_drain", A_NONE, 5'd0, 32'd0); chk("rx_drain.rx_valid", 32'(rx_valid), 32'd0);

        do_load(6'd0, 0);
        do_stop();
        do_load(6'd40, 32);
        do_stop();

        // Reset during LOAD_INSTR aborts with no further actions.
        cfg_plen = 6'd2;
        tick(); start = 1'b1;
        tick(); start = 1'b0;
        exp_act("abort0", A_INSTR, 5'd0, 32'h0000_6001);
        reset = 1'b0;
        tick();
        exp_act("abort1", A_NONE, 5'd0, 32'd0);
        chk("abort1.busy", 32'(busy), 32'd0);
        chk("abort1.running", 32'(running), 32'd0);
        chk("abort1.tx_ready", 32'(tx_ready), 32'd0);
        chk("abort1.rx_valid", 32'(rx_valid), 32'd0);
        chk("abort1.rx_data", rx_data, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_act("abort_quiet", A_NONE, 5'd0, 32'd0);
        end

        do_load(6'd2, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
